rvfpm_lsu_ctrl: RTL

RVFPM_LSU_CTRL -- requirements
Module: rvfpm_lsu_ctrl

---
 rtl/rvfpm_lsu_ctrl_if.sv | 53 +++++
 rtl/rvfpm_lsu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_lsu_ctrl_if.sv
// Load/store offload bundle between the FP decode stage, the CORE-V-XIF commit
// port and the memory interface of rvfpm_lsu_ctrl.
interface rvfpm_lsu_ctrl_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32
) ();
  localparam int REQ_W = X_ID_WIDTH + X_MEM_WIDTH + 46;
  localparam int RES_W = X_ID_WIDTH + X_MEM_WIDTH + 2;

  logic                   ls_valid;
  logic                   ls_ready;
  logic [X_ID_WIDTH-1:0]  ls_id;
  logic                   ls_we;
  logic [31:0]            ls_addr;
  logic [X_MEM_WIDTH-1:0] ls_wdata;
  logic [4:0]             ls_rd;

  logic                   commit_valid;
  logic                   commit_kill;
  logic [X_ID_WIDTH-1:0]  commit_id;

  // mem_req = {id, addr, mode, we, size, be, attr[1:0], wdata, last, spec}
  logic                   mem_valid;
  logic                   mem_ready;
  logic [REQ_W-1:0]       mem_req;
  // mem_result = {id, rdata, err, dbg}
  logic                   mem_result_valid;
  logic [RES_W-1:0]       mem_result;

  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic [X_MEM_WIDTH-1:0] wb_data;
  logic [X_ID_WIDTH-1:0]  wb_id;
  logic                   exc_valid;
  logic [X_ID_WIDTH-1:0]  exc_id;
  logic                   busy;

  modport slave (
    input  ls_valid, ls_id, ls_we, ls_addr, ls_wdata, ls_rd,
    input  commit_valid, commit_kill, commit_id,
    input  mem_ready, mem_result_valid, mem_result,
    output ls_ready, mem_valid, mem_req,
    output wb_valid, wb_rd, wb_data, wb_id, exc_valid, exc_id, busy
  );

  modport master (
    output ls_valid, ls_id, ls_we, ls_addr, ls_wdata, ls_rd,
    output commit_valid, commit_kill, commit_id,
    output mem_ready, mem_result_valid, mem_result,
    input  ls_ready, mem_valid, mem_req,
    input  wb_valid, wb_rd, wb_data, wb_id, exc_valid, exc_id, busy
  );
endinterface

// File: rtl/rvfpm_lsu_ctrl.sv
// FLW/FSW sequencer: queues offloaded loads/stores, waits for commit or kill,
// and issues one aligned word access at a time to the memory interface.
module rvfpm_lsu_ctrl #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32,
  parameter int QDEPTH      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  rvfpm_lsu_ctrl_if.slave   lsu
);
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = $clog2(QDEPTH + 1);
  localparam int REQ_W = X_ID_WIDTH + X_MEM_WIDTH + 46;
  localparam int RES_W = X_ID_WIDTH + X_MEM_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  typedef struct packed {
    logic                   vld;
    logic                   cmt;
    logic                   kill;
    logic [X_ID_WIDTH-1:0]  id;
    logic                   we;
    logic [31:0]            addr;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic [4:0]             rd;
  } entry_t;

  entry_t                 q_q [QDEPTH];
  entry_t                 q_d [QDEPTH];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  state_e                 state_q, state_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [REQ_W-1:0]       mem_req_q, mem_req_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [X_MEM_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [X_ID_WIDTH-1:0]  wb_id_q, wb_id_d;
  logic                   exc_valid_q, exc_valid_d;
  logic [X_ID_WIDTH-1:0]  exc_id_q, exc_id_d;

  entry_t                 head_s;
  logic                   full_s, push_s, pop_s;
  logic [X_ID_WIDTH-1:0]  res_id_s;
  logic [X_MEM_WIDTH-1:0] res_rdata_s;
  logic                   res_err_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign head_s      = q_q[head_q];
  assign full_s      = (count_q == CW'(QDEPTH));
  assign push_s      = lsu.ls_valid && !full_s;
  assign res_id_s    = lsu.mem_result[RES_W-1 -: X_ID_WIDTH];
  assign res_rdata_s = lsu.mem_result[X_MEM_WIDTH+1:2];
  assign res_err_s   = lsu.mem_result[1];

  assign lsu.ls_ready  = !full_s;
  assign lsu.busy      = (count_q != '0) || (state_q != S_IDLE);
  assign lsu.mem_valid = mem_valid_q;
  assign lsu.mem_req   = mem_req_q;
  assign lsu.wb_valid  = wb_valid_q;
  assign lsu.wb_rd     = wb_rd_q;
  assign lsu.wb_data   = wb_data_q;
  assign lsu.wb_id     = wb_id_q;
  assign lsu.exc_valid = exc_valid_q;
  assign lsu.exc_id    = exc_id_q;

  // Next-state logic for queue, commit/kill flags, FSM and registered outputs.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) q_d[i] = q_q[i];
    head_d      = head_q;
    tail_d      = tail_q;
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_req_d   = mem_req_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_id_d     = wb_id_q;
    exc_valid_d = 1'b0;
    exc_id_d    = exc_id_q;
    pop_s       = 1'b0;

    if (push_s) begin
      q_d[tail_q] = '{vld: 1'b1, cmt: 1'b0, kill: 1'b0, id: lsu.ls_id, we: lsu.ls_we,
                      addr: lsu.ls_addr, wdata: lsu.ls_wdata, rd: lsu.ls_rd};
      tail_d = ptr_inc(tail_q);
    end

    // Commit/kill sees the just-pushed entry; the issued head ignores kills.
    for (int i = 0; i < QDEPTH; i++) begin
      if (lsu.commit_valid && q_d[i].vld && (q_d[i].id == lsu.commit_id)) begin
        if (!lsu.commit_kill) begin
          q_d[i].cmt = 1'b1;
        end else if (!((head_q == PW'(i)) && (state_q != S_IDLE))) begin
          q_d[i].kill = 1'b1;
        end else begin
          q_d[i].kill = q_q[i].kill;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (head_s.vld && head_s.kill) begin
          state_d = S_DROP;
        end else if (head_s.vld && head_s.cmt) begin
          if (head_s.addr[1:0] == 2'b00) begin
            state_d     = S_REQ;
            mem_valid_d = 1'b1;
            mem_req_d   = {head_s.id, head_s.addr, 2'b11, head_s.we, 3'b010, 4'hF, 2'b00,
                           head_s.we ? head_s.wdata : {X_MEM_WIDTH{1'b0}}, 1'b1, 1'b0};
          end else begin
            exc_valid_d = 1'b1;
            exc_id_d    = head_s.id;
            pop_s       = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (lsu.mem_ready) begin
          state_d     = S_WAIT;
          mem_valid_d = 1'b0;
          mem_req_d   = '0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (lsu.mem_result_valid && (res_id_s == head_s.id)) begin
          state_d = S_IDLE;
          pop_s   = 1'b1;
          if (res_err_s) begin
            exc_valid_d = 1'b1;
            exc_id_d    = head_s.id;
          end else if (!head_s.we) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = head_s.rd;
            wb_data_d  = res_rdata_s;
            wb_id_d    = head_s.id;
          end else begin
            wb_valid_d = 1'b0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        state_d = S_IDLE;
        pop_s   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop_s) begin
      q_d[head_q].vld = 1'b0;
      head_d = ptr_inc(head_q);
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      mem_req_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      wb_id_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_id_q    <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= q_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_req_q   <= mem_req_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_id_q     <= wb_id_d;
      exc_valid_q <= exc_valid_d;
      exc_id_q    <= exc_id_d;
    end
  end
endmodule
